// File: rtl/fetch_seq_ctrl_if.sv
// Instruction-memory request/acknowledge port used by the fetch sequencer.
interface fetch_seq_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns pc_f and the IF/ID register, runs a variable-latency
// req/ack fetch port, absorbs ID stalls in a one-entry skid buffer and applies
// branch/jump redirects with delay-slot semantics.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | post-reset bubble, no request; moves to ST_FETCH next cycle
//   ST_FETCH | imem_req high for address pc_f until imem_ack
//   ST_HOLD  | skid buffer full, no request; drains into IF/ID when ID frees
module fetch_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_d,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   fetch_seq_ctrl_if.master   imem,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   output logic [31:0]        pc_f
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_tgt_q, redir_tgt_d;

   logic        redir_take;
   logic        fetch_done;
   logic        ifid_blocked;

   // A redirect seen while ID is stalled is dropped; the next-PC logic repeats it.
   assign redir_take   = redirect_valid & ~stall_d;
   assign fetch_done   = (state_q == ST_FETCH) & imem.imem_ack;
   assign ifid_blocked = stall_d & if_valid_q;

   // Next-state, PC, IF/ID and skid-buffer update
   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            if (redir_take) begin
               pc_f_d = redirect_pc;
            end
            if (!stall_d) begin
               if_valid_d = 1'b0;
            end
         end

         ST_FETCH: begin
            if (fetch_done) begin
               if (ifid_blocked) begin
                  buf_instr_d = imem.imem_rdata;
                  buf_pc_d    = pc_f_q;
                  state_d     = ST_HOLD;
               end else begin
                  if_valid_d = 1'b1;
                  if_instr_d = imem.imem_rdata;
                  if_pc_d    = pc_f_q;
               end
               // The completing fetch is the delay slot of any redirect in flight.
               if (redir_take) begin
                  pc_f_d       = redirect_pc;
                  redir_pend_d = 1'b0;
               end else if (redir_pend_q) begin
                  pc_f_d       = redir_tgt_q;
                  redir_pend_d = 1'b0;
               end else begin
                  pc_f_d = pc_f_q + 32'd4;
               end
            end else begin
               // The address must stay put until ack, so park the target.
               if (redir_take) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = redirect_pc;
               end
               if (!ifid_blocked && !stall_d) begin
                  if_valid_d = 1'b0;
               end
            end
         end

         ST_HOLD: begin
            if (!stall_d) begin
               if_valid_d = 1'b1;
               if_instr_d = buf_instr_q;
               if_pc_d    = buf_pc_q;
               state_d    = ST_FETCH;
               // Buffer already holds the delay slot; the target is next.
               if (redir_take) begin
                  pc_f_d = redirect_pc;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_f_q       <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_instr_q   <= 32'd0;
         if_pc_q      <= 32'd0;
         buf_instr_q  <= 32'd0;
         buf_pc_q     <= 32'd0;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
      end
   end

   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_f_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc          = if_pc_q;
   assign pc_f           = pc_f_q;

endmodule
